time_setter: RTL and testbench
==============================

Name: time_setter

Overview:
- User-facing entry block that writes the programmed start time into the egg-timer's down-counting digit chain.
- Debounces up/down/start buttons and edits a 3-digit M:SS BCD value with wrap-around and auto-repeat.
- Issues a single-cycle load pulse so the digit counters capture the value.
- Tracks IDLE/SET/RUN so edits are locked out while the timer counts down.

Parameters:
- DEBOUNCE_COUNT, 4, consecutive tick pulses a synchronized button level must hold before the debounced level changes.
- REPEAT_DELAY, 5, ticks a held up/down button must stay pressed before the first auto-repeat step.
- REPEAT_RATE, 2, ticks between subsequent auto-repeat steps.
- CTR_WIDTH, 8, width of the debounce and repeat counters; must hold max(DEBOUNCE_COUNT, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- tick  input  1  one-cycle enable pulse from clock_divider; paces debounce and repeat counters
- btn_up  input  1  raw up button, active-high, asynchronous to clk
- btn_down  input  1  raw down button, active-high, asynchronous
- btn_start  input  1  raw start/abort button, active-high, asynchronous
- count_done  input  1  terminal-count flag from the minutes digit_counter chain (all digits zero)
- min_ones  output  4  programmed minutes digit, BCD 0-9
- sec_tens  output  4  programmed seconds tens digit, BCD 0-5
- sec_ones  output  4  programmed seconds ones digit, BCD 0-9
- load  output  1  one-cycle pulse; digit counters capture min_ones/sec_tens/sec_ones
- setting  output  1  high in SET state (drives display blink)
- running  output  1  high in RUN state

Behaviour:
- Reset (reset=0, async): min_ones=0, sec_tens=0, sec_ones=0, load=0, setting=0, running=0, state=IDLE. All synchronizers, debounced levels, counters and edge registers are cleared to 0.
- Synchronizer: each raw button passes through 2 flops on clk.
- Debounce:
  - A per-button counter increments on tick while the synced level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_COUNT, the debounced level toggles and the counter clears.
  - Counter updates happen only on cycles with tick=1.
- Press event: rising edge of a debounced level, registered. Any step or state change takes effect on the clk edge after the debounced level rises (1 clk latency).
- Auto-repeat (up/down only):
  - While the debounced level is held high, a repeat counter counts ticks.
  - The first repeat step fires at REPEAT_DELAY ticks after the press; subsequent steps fire every REPEAT_RATE ticks.
  - Releasing the button clears the counter.
- Step arithmetic on M:SS:
  - Up: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; 9:59 -> 0:00.
  - Down: borrows symmetrically; 0:00 -> 9:59.
  - Digits never leave their legal BCD ranges.
- Simultaneous up and down steps in the same cycle: no change.
- FSM:
  - IDLE: an up/down event goes to SET and applies the step in the same edge. A start event with value != 0:00 pulses load and goes to RUN. A start event with value 0:00 is ignored.
  - SET: up/down events step the value. A start event with value != 0:00 pulses load and goes to RUN; with value 0:00 it stays in SET.
  - RUN: up/down events are ignored and their repeat counters are held cleared. count_done=1 goes to IDLE with the value retained. A start event aborts to SET (no load). If count_done and a start event coincide, count_done wins and the FSM goes to IDLE.
- load: high exactly one clk, in the cycle the FSM enters RUN. Digit outputs are stable during that cycle and the one before it.
- setting = (state==SET); running = (state==RUN); both registered.
- Reset mid-RUN or mid-press: immediate return to reset values. A button held through reset release must first debounce high before it produces an event.

Test Plan:
- Reset, then hold btn_up for 3 ticks and release -> no debounced event; digits remain 0:00; state IDLE.
- From 0:00, one clean btn_up press held for 4 ticks then released -> 0:01, setting=1, exactly one step.
- From 0:59, press up -> 1:00. From 0:00, press down -> 9:59. From 9:59, press up -> 0:00.
- From 0:00, hold btn_up for 5+2*3 ticks past debounce -> 1 initial step + 1 at delay + 3 repeats = 0:05.
- Set 0:02, press start -> load high exactly 1 clk with sec_ones=2, running=1. Then press up -> value unchanged. Then assert count_done -> IDLE, value 0:02 retained.
- At 0:00 in SET, press start -> no load, stays in SET. Pulse reset low during RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/time_setter.sv
`timescale 1ns/1ps
// time_setter: button front end for the egg timer. It synchronizes and
// debounces the up/down/start buttons, edits an M:SS BCD start value with
// wrap-around and auto-repeat, and hands the value to the digit counters
// with a one-cycle load pulse when the countdown starts.
//
//   state | meaning
//   IDLE  | value shown, no edit in progress, not counting
//   SET   | user is editing the value (display blinks)
//   RUN   | digit chain is counting down, edits locked out
module time_setter #(
  parameter int DEBOUNCE_COUNT = 4,
  parameter int REPEAT_DELAY   = 5,
  parameter int REPEAT_RATE    = 2,
  parameter int CTR_WIDTH      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       count_done,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       load,
  output logic       setting,
  output logic       running
);

  // Counters compare against N-1 so the action lands on the N-th tick.
  localparam logic [CTR_WIDTH-1:0] DB_LAST    = CTR_WIDTH'(DEBOUNCE_COUNT - 1);
  localparam logic [CTR_WIDTH-1:0] DELAY_LAST = CTR_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CTR_WIDTH-1:0] RATE_LAST  = CTR_WIDTH'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SET  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Button index: 0 = up, 1 = down, 2 = start.
  logic [2:0]                w_btn_raw;
  logic [2:0]                r_sync1;
  logic [2:0]                r_sync2;
  logic [2:0]                r_db;
  logic [2:0]                r_db_d;
  logic [2:0][CTR_WIDTH-1:0] r_db_cnt;
  logic [2:0]                w_press;

  logic [1:0][CTR_WIDTH-1:0] r_rep_cnt;
  logic [1:0]                r_rep_armed;
  logic [1:0][CTR_WIDTH-1:0] w_rep_target;
  logic [1:0]                w_rep_step;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_in_run;
  logic                      w_up_ev;
  logic                      w_dn_ev;
  logic                      w_start_ev;
  logic                      w_val_nz;
  logic                      w_load_nxt;
  logic                      w_step_up;
  logic                      w_step_dn;

  logic [3:0]                r_min_ones;
  logic [3:0]                r_sec_tens;
  logic [3:0]                r_sec_ones;
  logic [3:0]                w_inc_min;
  logic [3:0]                w_inc_tens;
  logic [3:0]                w_inc_ones;
  logic [3:0]                w_dec_min;
  logic [3:0]                w_dec_tens;
  logic [3:0]                w_dec_ones;
  logic                      r_load;
  logic                      r_setting;
  logic                      r_running;

  assign w_btn_raw = {btn_start, btn_down, btn_up};
  assign w_in_run  = (r_state == ST_RUN);

  // Two-flop synchronizer for the asynchronous raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the debounced level flips after DEBOUNCE_COUNT consecutive
  // ticks on which the synchronized level disagrees with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db     <= '0;
      r_db_cnt <= '0;
    end else if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db[i]     <= ~r_db[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + CTR_WIDTH'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Delayed debounced levels for rising-edge press detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_d <= '0;
    end else begin
      r_db_d <= r_db;
    end
  end

  assign w_press = r_db & ~r_db_d;

  // Repeat step fires when the held-tick counter reaches the first delay,
  // then the shorter rate once armed; never while counting down.
  always_comb begin
    w_rep_target = '0;
    w_rep_step   = '0;
    for (int i = 0; i < 2; i++) begin
      w_rep_target[i] = r_rep_armed[i] ? RATE_LAST : DELAY_LAST;
      w_rep_step[i]   = tick & r_db[i] & ~w_in_run & (r_rep_cnt[i] == w_rep_target[i]);
    end
  end

  // Auto-repeat counters for up/down, cleared on release and while running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!r_db[i] || w_in_run) begin
          r_rep_cnt[i]   <= '0;
          r_rep_armed[i] <= 1'b0;
        end else if (tick) begin
          if (w_rep_step[i]) begin
            r_rep_cnt[i]   <= '0;
            r_rep_armed[i] <= 1'b1;
          end else begin
            r_rep_cnt[i] <= r_rep_cnt[i] + CTR_WIDTH'(1);
          end
        end
      end
    end
  end

  assign w_up_ev    = w_press[0] | w_rep_step[0];
  assign w_dn_ev    = w_press[1] | w_rep_step[1];
  assign w_start_ev = w_press[2];
  assign w_val_nz   = |{r_min_ones, r_sec_tens, r_sec_ones};

  // M:SS increment with carries; 9:59 wraps to 0:00.
  always_comb begin
    w_inc_min  = r_min_ones;
    w_inc_tens = r_sec_tens;
    w_inc_ones = r_sec_ones + 4'd1;
    if (r_sec_ones >= 4'd9) begin
      w_inc_ones = 4'd0;
      w_inc_tens = r_sec_tens + 4'd1;
      if (r_sec_tens >= 4'd5) begin
        w_inc_tens = 4'd0;
        w_inc_min  = (r_min_ones >= 4'd9) ? 4'd0 : r_min_ones + 4'd1;
      end
    end
  end

  // M:SS decrement with borrows; 0:00 wraps to 9:59.
  always_comb begin
    w_dec_min  = r_min_ones;
    w_dec_tens = r_sec_tens;
    w_dec_ones = r_sec_ones - 4'd1;
    if (r_sec_ones == 4'd0) begin
      w_dec_ones = 4'd9;
      w_dec_tens = r_sec_tens - 4'd1;
      if (r_sec_tens == 4'd0) begin
        w_dec_tens = 4'd5;
        w_dec_min  = (r_min_ones == 4'd0) ? 4'd9 : r_min_ones - 4'd1;
      end
    end
  end

  // Next-state logic. Start wins over a step so the value is frozen in the
  // load cycle; opposing up and down steps cancel out.
  always_comb begin
    w_state_nxt = r_state;
    w_load_nxt  = 1'b0;
    w_step_up   = 1'b0;
    w_step_dn   = 1'b0;
    case (r_state)
      ST_IDLE, ST_SET: begin
        if (w_start_ev && w_val_nz) begin
          w_state_nxt = ST_RUN;
          w_load_nxt  = 1'b1;
        end else if (w_up_ev ^ w_dn_ev) begin
          w_state_nxt = ST_SET;
          w_step_up   = w_up_ev;
          w_step_dn   = w_dn_ev;
        end
      end
      ST_RUN: begin
        if (count_done) begin
          w_state_nxt = ST_IDLE;
        end else if (w_start_ev) begin
          w_state_nxt = ST_SET;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus registered status outputs and load pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_load    <= 1'b0;
      r_setting <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_load    <= w_load_nxt;
      r_setting <= (w_state_nxt == ST_SET);
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  // Programmed value, stepped only when the FSM accepts an edit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_min_ones <= '0;
      r_sec_tens <= '0;
      r_sec_ones <= '0;
    end else if (w_step_up) begin
      r_min_ones <= w_inc_min;
      r_sec_tens <= w_inc_tens;
      r_sec_ones <= w_inc_ones;
    end else if (w_step_dn) begin
      r_min_ones <= w_dec_min;
      r_sec_tens <= w_dec_tens;
      r_sec_ones <= w_dec_ones;
    end
  end

  assign min_ones = r_min_ones;
  assign sec_tens = r_sec_tens;
  assign sec_ones = r_sec_ones;
  assign load     = r_load;
  assign setting  = r_setting;
  assign running  = r_running;

endmodule

// File: tb/tb_time_setter.sv
`timescale 1ns/1ps
// Bench for time_setter: a seconds-count model with window-based debounce
// and held-tick repeat arithmetic, checked against the DUT every cycle,
// plus literal expectations after each directed step.
module tb_time_setter;

  localparam int DBC = 4;
  localparam int RD  = 5;
  localparam int RR  = 2;
  localparam int M_IDLE = 0;
  localparam int M_SET  = 1;
  localparam int M_RUN  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_start = 1'b0;
  logic       count_done = 1'b0;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       load;
  logic       setting;
  logic       running;

  time_setter #(
    .DEBOUNCE_COUNT(DBC),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .CTR_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_start(btn_start),
    .count_done(count_done),
    .min_ones(min_ones),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .load(load),
    .setting(setting),
    .running(running)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tick_phase = 0;
  int load_cnt = 0;
  logic [3:0] load_ones = 4'd0;

  // one tick every 4 clocks
  initial begin
    forever begin
      @(negedge clk);
      tick = (tick_phase % 4 == 3);
      tick_phase++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_s1 [3];
  bit m_s2 [3];
  bit m_db [3];
  bit m_db_d [3];
  bit m_win [3][DBC];
  int m_held [2];
  int m_val;
  int m_mode;
  bit m_load;
  bit pr [3];
  bit rp [2];
  bit raw [3];
  bit up_e, dn_e, all_diff;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_db_d[b] = 0;
        for (int k = 0; k < DBC; k++) m_win[b][k] = 0;
      end
      m_held[0] = 0; m_held[1] = 0;
      m_val = 0; m_mode = M_IDLE; m_load = 0;
    end else begin
      raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_start;
      for (int b = 0; b < 3; b++) pr[b] = m_db[b] && !m_db_d[b];
      for (int b = 0; b < 2; b++) begin
        rp[b] = 0;
        if (!m_db[b] || m_mode == M_RUN) m_held[b] = 0;
        else if (tick) begin
          m_held[b]++;
          if (m_held[b] == RD || (m_held[b] > RD && (m_held[b] - RD) % RR == 0)) rp[b] = 1;
        end
      end
      up_e = pr[0] | rp[0];
      dn_e = pr[1] | rp[1];
      m_load = 0;
      if (m_mode == M_RUN) begin
        if (count_done) m_mode = M_IDLE;
        else if (pr[2]) m_mode = M_SET;
      end else begin
        if (pr[2] && m_val != 0) begin
          m_mode = M_RUN; m_load = 1;
        end else if (up_e != dn_e) begin
          m_val = up_e ? (m_val + 1) % 600 : (m_val + 599) % 600;
          m_mode = M_SET;
        end
      end
      for (int b = 0; b < 3; b++) begin
        m_db_d[b] = m_db[b];
        if (tick) begin
          for (int k = DBC - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
          m_win[b][0] = m_s2[b];
          all_diff = 1;
          for (int k = 0; k < DBC; k++) if (m_win[b][k] == m_db[b]) all_diff = 0;
          if (all_diff) m_db[b] = !m_db[b];
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("min_ones", min_ones, m_val / 60);
    chk("sec_tens", sec_tens, (m_val % 60) / 10);
    chk("sec_ones", sec_ones, m_val % 10);
    chk("load", load, m_load);
    chk("setting", setting, m_mode == M_SET);
    chk("running", running, m_mode == M_RUN);
  end

  always @(negedge clk) begin
    if (load) begin
      load_cnt++;
      load_ones = sec_ones;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!tick);
    end
    @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_up = v;
      1: btn_down = v;
      default: btn_start = v;
    endcase
  endtask

  task automatic hold(input int b, input int n);
    set_btn(b, 1'b1);
    wait_ticks(n);
    set_btn(b, 1'b0);
    wait_ticks(8);
  endtask

  task automatic expect_state(input string name, input int val, input int mode);
    logic [11:0] e;
    e = {4'(val / 60), 4'((val % 60) / 10), 4'(val % 10)};
    chk({name, "_model_val"}, m_val, val);
    chk({name, "_model_mode"}, m_mode, mode);
    chk({name, "_digits"}, {min_ones, sec_tens, sec_ones}, e);
    chk({name, "_setting"}, setting, mode == M_SET);
    chk({name, "_running"}, running, mode == M_RUN);
  endtask

  int lc0;

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expect_state("reset", 0, M_IDLE);
    chk("reset_load", load, 0);
    wait_ticks(1);

    hold(0, 3);   expect_state("short_press", 0, M_IDLE);
    hold(0, 4);   expect_state("up_once", 1, M_SET);
    hold(1, 4);   expect_state("down_to_zero", 0, M_SET);
    hold(1, 4);   expect_state("down_wrap", 599, M_SET);
    hold(0, 4);   expect_state("up_wrap", 0, M_SET);
    hold(0, 11);  expect_state("repeat_5", 5, M_SET);
    hold(0, 109); expect_state("repeat_to_059", 59, M_SET);
    hold(0, 4);   expect_state("carry_100", 60, M_SET);
    hold(1, 4);   expect_state("borrow_059", 59, M_SET);
    hold(1, 119); expect_state("repeat_down_000", 0, M_SET);

    lc0 = load_cnt;
    hold(2, 4);   expect_state("start_at_zero", 0, M_SET);
    chk("start_zero_no_load", load_cnt - lc0, 0);

    hold(0, 4);
    hold(0, 4);   expect_state("set_002", 2, M_SET);
    lc0 = load_cnt;
    hold(2, 4);   expect_state("start_run", 2, M_RUN);
    chk("load_pulses", load_cnt - lc0, 1);
    chk("load_sec_ones", load_ones, 2);

    hold(0, 11);  expect_state("run_locked", 2, M_RUN);

    count_done = 1'b1;
    @(negedge clk);
    count_done = 1'b0;
    @(negedge clk);
    expect_state("count_done_idle", 2, M_IDLE);
    wait_ticks(1);

    lc0 = load_cnt;
    hold(2, 4);   expect_state("idle_start", 2, M_RUN);
    hold(2, 4);   expect_state("abort_set", 2, M_SET);
    chk("abort_no_load", load_cnt - lc0, 1);
    hold(2, 4);   expect_state("restart", 2, M_RUN);

    #2 reset = 1'b0;
    #1;
    chk("async_min", min_ones, 0);
    chk("async_tens", sec_tens, 0);
    chk("async_ones", sec_ones, 0);
    chk("async_running", running, 0);
    chk("async_setting", setting, 0);
    chk("async_load", load, 0);

    // button held through reset release must debounce before stepping
    btn_up = 1'b1;
    wait_ticks(1);
    reset = 1'b1;
    wait_ticks(2);
    expect_state("held_through_reset", 0, M_IDLE);
    wait_ticks(2);
    btn_up = 1'b0;
    wait_ticks(8);
    expect_state("held_after_debounce", 1, M_SET);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
